audio_dsp_pipe: RTL and testbench

//  Parametrised multi-channel sample processor between the audio receiver and the visualiser/output path.

---
 rtl/audio_dsp_pipe.sv | 174 +++++++++++++++++
 tb/tb_audio_dsp_pipe.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/audio_dsp_pipe.sv
// Multi-channel PCM sample processor: captures one frame, processes channels serially
// (bypass / saturating gain / moving average / saturating negate) and emits the frame.
// A new frame is accepted only in S_IDLE, i.e. from edge E+N_CH+2 onward after capture
// edge E, so the minimum frame spacing is N_CH+2 cycles.
module audio_dsp_pipe #(
  parameter int DATA_W   = 16,
  parameter int N_CH     = 2,
  parameter int AVG_LOG2 = 2,
  parameter int GAIN_W   = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [N_CH*DATA_W-1:0]   i_data,
  input  logic [1:0]               i_mode,
  input  logic [GAIN_W-1:0]        i_gain,
  output logic [N_CH*DATA_W-1:0]   o_data,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic                     o_overrun
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = DATA_W + AVG_LOG2;
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int FULL_W = DATA_W + (1 << GAIN_W) - 1;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_GAIN   = 2'd1;
  localparam logic [1:0] MODE_AVG    = 2'd2;
  localparam logic [1:0] MODE_NEG    = 2'd3;

  localparam logic signed [DATA_W-1:0] SMP_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SMP_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [FULL_W-1:0] SAT_MAX = {{(FULL_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [FULL_W-1:0] SAT_MIN = {{(FULL_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic                    accept, run_en, done_en, last_ch;
  logic [N_CH*DATA_W-1:0]  frame_q;
  logic [1:0]              mode_q;
  logic [GAIN_W-1:0]       gain_q;
  logic [CH_W-1:0]         ch_q;
  logic [AVG_LOG2-1:0]     wr_ptr_q;
  logic [N_CH*DATA_W-1:0]  shadow_q;
  logic [N_CH*DATA_W-1:0]  o_data_q;
  logic                    o_valid_q;
  logic                    overrun_q;

  logic signed [DATA_W-1:0] oldest_all [N_CH];
  logic signed [SUM_W-1:0]  sum_all    [N_CH];

  logic signed [DATA_W-1:0] x_cur, oldest_cur, y_cur;
  logic signed [SUM_W-1:0]  sum_cur, sum_nxt, x_sum_ext, old_sum_ext;
  logic signed [FULL_W-1:0] gain_ext, gain_full;

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_valid) state_d = S_RUN;
      S_RUN:   if (last_ch) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept  = (state_q == S_IDLE) && i_valid;
    run_en  = (state_q == S_RUN);
    done_en = (state_q == S_DONE);
    last_ch = (ch_q == CH_W'(N_CH - 1));
    o_busy  = (state_q != S_IDLE);
  end

  // ---------------- capture and channel sequencing ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_q <= '0;
      mode_q  <= '0;
      gain_q  <= '0;
      ch_q    <= '0;
    end else if (accept) begin
      frame_q <= i_data;
      mode_q  <= i_mode;
      gain_q  <= i_gain;
      ch_q    <= '0;
    end else if (run_en && !last_ch) begin
      ch_q <= ch_q + 1'b1;
    end
  end

  // ---------------- shared per-channel datapath ----------------
  always_comb begin
    x_cur       = frame_q[ch_q*DATA_W +: DATA_W];
    oldest_cur  = oldest_all[ch_q];
    sum_cur     = sum_all[ch_q];
    x_sum_ext   = {{AVG_LOG2{x_cur[DATA_W-1]}}, x_cur};
    old_sum_ext = {{AVG_LOG2{oldest_cur[DATA_W-1]}}, oldest_cur};
    sum_nxt     = sum_cur + x_sum_ext - old_sum_ext;
    gain_ext    = {{(FULL_W-DATA_W){x_cur[DATA_W-1]}}, x_cur};
    gain_full   = gain_ext <<< gain_q;
    y_cur       = x_cur;
    case (mode_q)
      MODE_BYPASS: y_cur = x_cur;
      MODE_GAIN: begin
        if (gain_full > SAT_MAX)      y_cur = SMP_MAX;
        else if (gain_full < SAT_MIN) y_cur = SMP_MIN;
        else                          y_cur = gain_full[DATA_W-1:0];
      end
      // Floor division of the window sum; the shift keeps the sign.
      MODE_AVG:    y_cur = DATA_W'(sum_nxt >>> AVG_LOG2);
      MODE_NEG:    y_cur = (x_cur == SMP_MIN) ? SMP_MAX : -x_cur;
      default:     y_cur = x_cur;
    endcase
  end

  // ---------------- per-channel history (updated in every mode) ----------------
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic signed [DATA_W-1:0] hist_q [DEPTH];
      logic signed [SUM_W-1:0]  sum_q;
      logic                     wr_en;

      assign wr_en = run_en && (ch_q == CH_W'(gi));

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          sum_q <= '0;
          for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
        end else if (wr_en) begin
          sum_q            <= sum_nxt;
          hist_q[wr_ptr_q] <= x_cur;
        end
      end

      assign oldest_all[gi] = hist_q[wr_ptr_q];
      assign sum_all[gi]    = sum_q;
    end
  endgenerate

  // ---------------- shadow, output and status ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow_q  <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      wr_ptr_q  <= '0;
    end else begin
      o_valid_q <= done_en;
      if (run_en) shadow_q[ch_q*DATA_W +: DATA_W] <= y_cur;
      if (done_en) begin
        o_data_q <= shadow_q;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (i_valid && (state_q != S_IDLE)) overrun_q <= 1'b1;
    end
  end

  assign o_data    = o_data_q;
  assign o_valid   = o_valid_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_audio_dsp_pipe.sv
// Directed bench for audio_dsp_pipe (defaults: DATA_W=16, N_CH=2, AVG_LOG2=2, GAIN_W=4).
module tb_audio_dsp_pipe;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_data;
  logic [1:0]  i_mode;
  logic [3:0]  i_gain;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_busy;
  logic        o_overrun;

  int chk_cnt = 0;
  int err_cnt = 0;

  audio_dsp_pipe dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .i_mode    (i_mode),
    .i_gain    (i_gain),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_busy    (o_busy),
    .o_overrun (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Sends one frame, waits (bounded) for o_valid, checks latency, data and pulse width.
  task automatic do_frame(input string tag, input logic [1:0] mode, input logic [3:0] gain,
                          input logic [15:0] c1, input logic [15:0] c0, input logic [31:0] exp);
    int lat;
    logic [31:0] res;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = {c1, c0};
    i_mode  = mode;
    i_gain  = gain;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_mode  = mode + 2'd1;
    i_gain  = 4'hF;
    lat = 0;
    while (!o_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
      if (!o_valid) check_val({tag, "_busy"}, 64'(o_busy), 64'(lat <= 2));
    end
    res = o_data;
    $display("frame %s mode=%0d gain=%0d in=%h out=%h lat=%0d", tag, mode, gain, {c1, c0}, res, lat);
    check_val({tag, "_lat"}, 64'(lat), 64'd3);
    check_val({tag, "_data"}, 64'(res), 64'(exp));
    @(posedge clk);
    #1;
    check_val({tag, "_pulse"}, 64'(o_valid), 64'd0);
    check_val({tag, "_hold"}, 64'(o_data), 64'(exp));
  endtask

  initial begin
    int pulses;
    logic [31:0] seen;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_mode  = '0;
    i_gain  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_data",    64'(o_data),    64'd0);
    check_val("rst_valid",   64'(o_valid),   64'd0);
    check_val("rst_busy",    64'(o_busy),    64'd0);
    check_val("rst_overrun", 64'(o_overrun), 64'd0);

    // Bypass
    do_frame("bypass", 2'd0, 4'd0, 16'h8000, 16'h1234, 32'h8000_1234);

    // Gain with saturation; mode/gain are changed right after capture
    do_frame("gain2a", 2'd1, 4'd2,  16'hFFFF, 16'h1000, 32'hFFFC_4000);
    do_frame("gain2b", 2'd1, 4'd2,  16'hC000, 16'h3000, 32'h8000_7FFF);
    do_frame("gain0",  2'd1, 4'd0,  16'h8000, 16'h1234, 32'h8000_1234);
    do_frame("gain15", 2'd1, 4'd15, 16'hFFFF, 16'h0001, 32'h8000_7FFF);

    // Negate
    do_frame("neg_a", 2'd3, 4'd0, 16'h0005, 16'h8000, 32'hFFFB_7FFF);
    do_frame("neg_b", 2'd3, 4'd0, 16'h0000, 16'h7FFF, 32'h0000_8001);

    // Moving average from a clean history: ch0=400, ch1=-3
    do_reset();
    do_frame("avg1", 2'd2, 4'd0, 16'hFFFD, 16'd400, 32'hFFFF_0064);
    do_frame("avg2", 2'd2, 4'd0, 16'hFFFD, 16'd400, 32'hFFFE_00C8);
    do_frame("avg3", 2'd2, 4'd0, 16'hFFFD, 16'd400, 32'hFFFD_012C);
    do_frame("avg4", 2'd2, 4'd0, 16'hFFFD, 16'd400, 32'hFFFD_0190);
    do_frame("avg5", 2'd2, 4'd0, 16'hFFFD, 16'd400, 32'hFFFD_0190);

    // Overrun: second strobe one cycle after the first is dropped
    check_val("ovr_before", 64'(o_overrun), 64'd0);
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 32'h1111_2222;
    i_mode  = 2'd0;
    @(negedge clk);
    i_data  = 32'h3333_4444;
    @(negedge clk);
    i_valid = 1'b0;
    pulses = 0;
    seen   = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_valid) begin
        pulses++;
        seen = o_data;
      end
    end
    $display("frame overrun in=11112222/33334444 out=%h pulses=%0d", seen, pulses);
    check_val("ovr_pulses", 64'(pulses), 64'd1);
    check_val("ovr_data",   64'(seen),   64'h1111_2222);
    check_val("ovr_flag",   64'(o_overrun), 64'd1);
    do_frame("ovr_next", 2'd0, 4'd0, 16'hABCD, 16'h0123, 32'hABCD_0123);
    check_val("ovr_sticky", 64'(o_overrun), 64'd1);

    // Reset while in S_RUN
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = {16'h7000, 16'h7000};
    i_mode  = 2'd2;
    @(negedge clk);
    i_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid_data",    64'(o_data),    64'd0);
    check_val("mid_busy",    64'(o_busy),    64'd0);
    check_val("mid_overrun", 64'(o_overrun), 64'd0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_valid) pulses++;
    end
    $display("frame midreset pulses=%0d", pulses);
    check_val("mid_novalid", 64'(pulses), 64'd0);
    do_frame("mid_avg", 2'd2, 4'd0, 16'hFFFD, 16'd400, 32'hFFFF_0064);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
